// File: rtl/io_pkg.sv
// Shared types and sizing helpers for the IO port bank.
package io_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } out_state_t;

   localparam int DEF_DW  = 8;
   localparam int DEF_NCH = 4;

   // One extra address bit so out-of-range channel numbers are representable.
   function automatic int calc_aw(input int nch);
      return $clog2(nch) + 1;
   endfunction

endpackage

// File: rtl/io_out_channel.sv
// One output channel: data register plus IDLE/PEND handshake FSM, or a
// direct-mode register with a one-cycle valid pulse when HS=0.
module io_out_channel
   import io_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter bit HS = 1'b1
) (
   input  logic          clk,
   input  logic          i_srst,
   input  logic          i_wr,
   input  logic [DW-1:0] i_data,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   output logic          o_busy,
   output logic          o_drop
);

   out_state_t    r_state;
   out_state_t    w_state_next;
   logic [DW-1:0] r_data;
   logic          r_pulse;
   logic          w_load;

   always_ff @(posedge clk) begin
      if (i_srst) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pulse <= i_wr && !HS;
         if (w_load) r_data <= i_data;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      o_drop       = 1'b0;
      if (!HS) begin
         w_load       = i_wr;
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_wr) begin
                  w_load       = 1'b1;
                  w_state_next = PEND;
               end
            end
            PEND: begin
               // A write only lands while the current word is being taken.
               if (i_wr) begin
                  if (i_ready) w_load = 1'b1;
                  else         o_drop = 1'b1;
               end else if (i_ready) begin
                  w_state_next = IDLE;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   assign o_data  = r_data;
   assign o_valid = HS ? (r_state == PEND) : r_pulse;
   assign o_busy  = HS && (r_state == PEND);

endmodule

// File: rtl/io_port_bank.sv
// Core-facing IO port bank: NCH one-entry input buffers with registered read
// port, NCH output channels, and a sticky error flag.
module io_port_bank
   import io_pkg::*;
#(
   parameter int             DW      = DEF_DW,
   parameter int             NCH     = DEF_NCH,
   parameter logic [NCH-1:0] HS_MASK = {NCH{1'b1}},
   localparam int            AW      = calc_aw(NCH)
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [AW-1:0]     PortAddr,
   input  logic              INportRead,
   input  logic              OUTportWrite,
   input  logic [DW-1:0]     Datain,
   output logic [DW-1:0]     Dataout,
   output logic [NCH-1:0]    InFull,
   output logic [NCH-1:0]    OutBusy,
   output logic              ErrFlag,
   input  logic [NCH*DW-1:0] InpExtWorld,
   input  logic [NCH-1:0]    InpValid,
   output logic [NCH-1:0]    InpAck,
   output logic [NCH*DW-1:0] OutExtWorld,
   output logic [NCH-1:0]    OutValid,
   input  logic [NCH-1:0]    OutReady
);

   logic [DW-1:0]  r_buf [NCH];
   logic [NCH-1:0] r_full;
   logic [DW-1:0]  r_dout;
   logic           r_err;
   logic [NCH-1:0] w_cap;
   logic [NCH-1:0] w_rd_hit;
   logic [NCH-1:0] w_wr_sel;
   logic [NCH-1:0] w_drop;
   logic [DW-1:0]  w_rd_data;
   logic           w_rd_full;
   logic           w_addr_ok;
   logic           w_err;

   assign w_addr_ok = (PortAddr < AW'(NCH));

   always_comb begin
      w_rd_data = '0;
      w_rd_full = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (PortAddr == AW'(i)) begin
            w_rd_data = r_buf[i];
            w_rd_full = r_full[i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign w_rd_hit[gi] = INportRead && (PortAddr == AW'(gi)) && r_full[gi];
         // A buffer being drained this cycle can be refilled in the same cycle.
         assign w_cap[gi]    = !Reset && InpValid[gi] && (!r_full[gi] || w_rd_hit[gi]);
         assign w_wr_sel[gi] = OUTportWrite && (PortAddr == AW'(gi));

         io_out_channel #(
            .DW (DW),
            .HS (HS_MASK[gi])
         ) u_out (
            .clk     (clk),
            .i_srst  (Reset),
            .i_wr    (w_wr_sel[gi]),
            .i_data  (Datain),
            .i_ready (OutReady[gi]),
            .o_data  (OutExtWorld[gi*DW +: DW]),
            .o_valid (OutValid[gi]),
            .o_busy  (OutBusy[gi]),
            .o_drop  (w_drop[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (w_cap[i]) r_buf[i] <= InpExtWorld[i*DW +: DW];
      end
      if (Reset) begin
         r_full <= '0;
      end else begin
         r_full <= w_cap | (r_full & ~w_rd_hit);
      end
   end

   assign w_err = (INportRead && !w_rd_full) || (OUTportWrite && !w_addr_ok) || (|w_drop);

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_dout <= '0;
         r_err  <= 1'b0;
      end else begin
         if (INportRead && w_addr_ok) r_dout <= w_rd_full ? w_rd_data : '0;
         if (w_err) r_err <= 1'b1;
      end
   end

   assign Dataout = r_dout;
   assign InFull  = r_full;
   assign ErrFlag = r_err;
   assign InpAck  = w_cap;

endmodule
